// File: rtl/midi_note_gate.sv
// midi_note_gate: monophonic MIDI note parser producing envelope trigger/dehold strobes.
// Define MIDI_NOTE_GATE_LEGATO_EN to suppress retrigger while a note is already held.
module midi_note_gate #(
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clk48m,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       trigger,
    output logic       dehold,
    output logic       gate,
    output logic [6:0] note,
    output logic [6:0] velocity
);

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;
    typedef enum logic [1:0] {K_OTHER, K_OFF, K_ON} kind_t;

    state_t     state_q;
    kind_t      kind_q;
    logic       len2_q;
    logic       match_q;
    logic [6:0] d1_q;
    logic       trig_q;
    logic       deh_q;
    logic       gate_q;
    logic [6:0] note_q;
    logic [6:0] vel_q;

    logic is_sys;
    logic is_stat;
    logic is_data;
    logic note_msg;
    logic on_evt;
    logic trig_d;
    logic deh_d;

    always_comb begin
        is_sys   = rx_valid && (rx_data[7:3] == 5'b11110);
        is_stat  = rx_valid && rx_data[7] && (rx_data[7:4] != 4'hF);
        is_data  = rx_valid && !rx_data[7];
        note_msg = is_data && (state_q == WAIT_D2)
                   && match_q && (kind_q != K_OTHER);
        on_evt   = note_msg && (kind_q == K_ON) && (rx_data[6:0] != 7'd0);
        deh_d    = note_msg && !on_evt && gate_q && (d1_q == note_q);
    end

`ifdef MIDI_NOTE_GATE_LEGATO_EN
    assign trig_d = on_evt && !gate_q;
`else
    assign trig_d = on_evt;
`endif

    // Real-time bytes (F8..FF) fall through every branch and leave state untouched.
    always_ff @(posedge clk48m or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            kind_q  <= K_OTHER;
            len2_q  <= 1'b0;
            match_q <= 1'b0;
            d1_q    <= 7'd0;
            trig_q  <= 1'b0;
            deh_q   <= 1'b0;
            gate_q  <= 1'b0;
            note_q  <= 7'd0;
            vel_q   <= 7'd0;
        end else begin
            trig_q <= trig_d;
            deh_q  <= deh_d;
            if (is_sys) begin
                state_q <= IDLE;
            end else if (is_stat) begin
                unique case (rx_data[7:4])
                    4'h8:    kind_q <= K_OFF;
                    4'h9:    kind_q <= K_ON;
                    default: kind_q <= K_OTHER;
                endcase
                len2_q  <= (rx_data[7:4] != 4'hC) && (rx_data[7:4] != 4'hD);
                match_q <= (rx_data[3:0] == CHANNEL);
                state_q <= WAIT_D1;
            end else if (is_data) begin
                unique case (state_q)
                    WAIT_D1: begin
                        d1_q    <= rx_data[6:0];
                        state_q <= len2_q ? WAIT_D2 : WAIT_D1;
                    end
                    WAIT_D2: state_q <= WAIT_D1;
                    default: state_q <= IDLE;
                endcase
            end
            if (on_evt) begin
                note_q <= d1_q;
                vel_q  <= rx_data[6:0];
                gate_q <= 1'b1;
            end else if (deh_d) begin
                gate_q <= 1'b0;
            end
        end
    end

    assign trigger  = trig_q;
    assign dehold   = deh_q;
    assign gate     = gate_q;
    assign note     = note_q;
    assign velocity = vel_q;

endmodule

// File: tb/tb_midi_note_gate.sv
// Directed-vector bench for midi_note_gate (CHANNEL=0).
// Expected values are hand-derived from the MIDI byte sequences applied.
module tb_midi_note_gate;

    logic       clk48m = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       trigger;
    logic       dehold;
    logic       gate;
    logic [6:0] note;
    logic [6:0] velocity;

    int nvec = 0;
    int nerr = 0;
    int trig_cnt = 0;
    int deh_cnt = 0;
    int both_cnt = 0;
    int t0;

    midi_note_gate #(.CHANNEL(4'd0)) dut (
        .clk48m   (clk48m),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .trigger  (trigger),
        .dehold   (dehold),
        .gate     (gate),
        .note     (note),
        .velocity (velocity)
    );

    always #10 clk48m = ~clk48m;

    always @(negedge clk48m) begin
        if (trigger) trig_cnt++;
        if (dehold) deh_cnt++;
        if (trigger && dehold) both_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Byte is sampled on the posedge between the two negedges.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk48m);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (n) @(negedge clk48m);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        do_reset();
        chk("rst_trig", int'(trigger), 0);
        chk("rst_deh", int'(dehold), 0);
        chk("rst_gate", int'(gate), 0);
        chk("rst_note", int'(note), 0);
        chk("rst_vel", int'(velocity), 0);

        send(8'h90); send(8'h3C); send(8'h64);
        chk("on_trig", int'(trigger), 1);
        chk("on_deh", int'(dehold), 0);
        chk("on_gate", int'(gate), 1);
        chk("on_note", int'(note), 'h3C);
        chk("on_vel", int'(velocity), 'h64);
        idle(1);
        chk("on_trig_1cyc", int'(trigger), 0);

        send(8'h40); send(8'h00);
        chk("rs_off_other_deh", int'(dehold), 0);
        chk("rs_off_other_gate", int'(gate), 1);
        send(8'h3C); send(8'h00);
        chk("rs_off_deh", int'(dehold), 1);
        chk("rs_off_gate", int'(gate), 0);
        chk("rs_off_note", int'(note), 'h3C);
        chk("rs_off_vel", int'(velocity), 'h64);
        idle(1);
        chk("rs_off_deh_1cyc", int'(dehold), 0);

        send(8'h91); send(8'h3C); send(8'h64);
        chk("ch1_trig", int'(trigger), 0);
        chk("ch1_gate", int'(gate), 0);
        send(8'h90); send(8'h3C); send(8'h64);
        chk("ch0_trig", int'(trigger), 1);
        send(8'h80); send(8'h3C); send(8'h40);
        chk("ch0_off_deh", int'(dehold), 1);
        chk("ch0_off_trig", int'(trigger), 0);
        chk("ch0_off_gate", int'(gate), 0);

        do_reset();
        send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64);
        chk("rt_trig", int'(trigger), 1);
        chk("rt_note", int'(note), 'h3C);
        chk("rt_vel", int'(velocity), 'h64);
        idle(2);
        t0 = trig_cnt;
        send(8'hF0); send(8'h3C); send(8'h64);
        idle(2);
        chk("sysex_trig_cnt", trig_cnt, t0);
        chk("sysex_gate", int'(gate), 1);
        send(8'h80); send(8'h3C); send(8'h00);
        chk("sysex_then_off_deh", int'(dehold), 1);
        idle(2);

        t0 = trig_cnt;
        send(8'h90); send(8'h3C); send(8'hB0); send(8'h07);
        send(8'h7F); send(8'h3C); send(8'h64);
        idle(2);
        chk("abort_trig_cnt", trig_cnt, t0);
        chk("abort_gate", int'(gate), 0);

        send(8'hC0); send(8'h05); send(8'h3C); send(8'h64);
        send(8'hD0); send(8'h3C);
        idle(2);
        chk("pc_at_trig_cnt", trig_cnt, t0);

        send(8'h90);
        idle(1);
        #3 rst = 1'b1;
        #3 rst = 1'b0;
        idle(1);
        send(8'h3C); send(8'h64);
        idle(2);
        chk("midrst_trig_cnt", trig_cnt, t0);
        chk("midrst_gate", int'(gate), 0);

        send(8'h90); send(8'h3C); send(8'h64);
        send(8'h90); send(8'h40); send(8'h50);
`ifdef MIDI_NOTE_GATE_LEGATO_EN
        chk("retrig_trig", int'(trigger), 0);
`else
        chk("retrig_trig", int'(trigger), 1);
`endif
        chk("retrig_note", int'(note), 'h40);
        chk("retrig_vel", int'(velocity), 'h50);
        chk("retrig_gate", int'(gate), 1);
        idle(2);
`ifdef MIDI_NOTE_GATE_LEGATO_EN
        chk("retrig_cnt", trig_cnt - t0, 1);
`else
        chk("retrig_cnt", trig_cnt - t0, 2);
`endif
        send(8'h80); send(8'h3C); send(8'h00);
        chk("stale_off_deh", int'(dehold), 0);
        send(8'h40); send(8'h00);
        chk("held_off_deh", int'(dehold), 1);
        chk("held_off_gate", int'(gate), 0);
        idle(2);
        chk("both_never", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
